vga_frame_sequencer: RTL and testbench

//  Sequences the VGA output path. Walks the 640x480@60 raster on boardCLK, paced by the

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 39 +++
 rtl/vga_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and handshake state type
// shared by the VGA frame sequencer and its axis counters.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam logic VGA_SYNC_POL = 1'b0;
    localparam int   VGA_CW       = 10;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } hs_state_t;

    // Drive level of a sync line given whether the counter is inside its window.
    function automatic logic sync_level(input logic in_window,
                                        input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping raster axis counter with enable, reporting
// wrap, active-region and sync-window flags from the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CW         = VGA_CW,
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int ACTIVE     = VGA_H_ACTIVE,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          in_sync
);

    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT   = CW'(ACTIVE);
    localparam logic [CW-1:0] S_LO  = CW'(SYNC_START);
    localparam logic [CW-1:0] S_HI  = CW'(SYNC_END);

    // wrap is qualified by en so it can directly enable the next axis
    assign wrap    = en && (count == LAST);
    assign active  = count < ACT;
    assign in_sync = (count >= S_LO) && (count <= S_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA raster sequencer: timing counters, one-pixel output pipeline,
// and a once-per-frame vblank update handshake with overrun tracking.
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FRONT  = VGA_H_FRONT,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BACK   = VGA_H_BACK,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FRONT  = VGA_V_FRONT,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BACK   = VGA_V_BACK,
    parameter logic SYNC_POL = VGA_SYNC_POL,
    parameter int   CW       = VGA_CW
) (
    input  logic          boardCLK,
    input  logic          reset,
    input  logic          pixEn,
    input  logic [11:0]   colorIn,
    input  logic          updateAck,
    output logic [3:0]    redVGA,
    output logic [3:0]    greenVGA,
    output logic [3:0]    blueVGA,
    output logic          horizontalVGA,
    output logic          verticalVGA,
    output logic [CW-1:0] pixelX,
    output logic [CW-1:0] pixelY,
    output logic          videoOn,
    output logic          frameStart,
    output logic          updateReq,
    output logic          overrun,
    output logic [7:0]    overrunCount
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam logic [CW-1:0] V_LAST_ACTIVE = CW'(V_ACTIVE - 1);

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_active;
    logic          v_active;
    logic          h_sync;
    logic          v_sync;
    logic          frame_step;
    logic          vblank_entry;
    hs_state_t     state;

    vga_axis_counter #(
        .CW        (CW),
        .TOTAL     (H_TOTAL),
        .ACTIVE    (H_ACTIVE),
        .SYNC_START(H_SYNC_START),
        .SYNC_END  (H_SYNC_END)
    ) u_h_axis (
        .clk    (boardCLK),
        .rst    (reset),
        .en     (pixEn),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_active),
        .in_sync(h_sync)
    );

    vga_axis_counter #(
        .CW        (CW),
        .TOTAL     (V_TOTAL),
        .ACTIVE    (V_ACTIVE),
        .SYNC_START(V_SYNC_START),
        .SYNC_END  (V_SYNC_END)
    ) u_v_axis (
        .clk    (boardCLK),
        .rst    (reset),
        .en     (h_wrap),
        .count  (v_count),
        .wrap   (v_wrap),
        .active (v_active),
        .in_sync(v_sync)
    );

    assign pixelX  = h_count;
    assign pixelY  = v_count;
    assign videoOn = h_active && v_active;

    // Counter step events: to (0,0) and to (0,V_ACTIVE)
    assign frame_step   = h_wrap && v_wrap;
    assign vblank_entry = h_wrap && (v_count == V_LAST_ACTIVE);

    always_ff @(posedge boardCLK or posedge reset) begin
        if (reset) begin
            horizontalVGA <= ~SYNC_POL;
            verticalVGA   <= ~SYNC_POL;
            redVGA        <= '0;
            greenVGA      <= '0;
            blueVGA       <= '0;
        end else if (pixEn) begin
            horizontalVGA <= sync_level(h_sync, SYNC_POL);
            verticalVGA   <= sync_level(v_sync, SYNC_POL);
            if (videoOn) begin
                redVGA   <= colorIn[11:8];
                greenVGA <= colorIn[7:4];
                blueVGA  <= colorIn[3:0];
            end else begin
                redVGA   <= '0;
                greenVGA <= '0;
                blueVGA  <= '0;
            end
        end
    end

    always_ff @(posedge boardCLK or posedge reset) begin
        if (reset) begin
            frameStart <= 1'b0;
        end else begin
            frameStart <= frame_step;
        end
    end

    // An ack arriving on the frame step itself wins over the overrun.
    always_ff @(posedge boardCLK or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            updateReq    <= 1'b0;
            overrun      <= 1'b0;
            overrunCount <= '0;
        end else begin
            overrun <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (vblank_entry) begin
                        state     <= ST_REQ;
                        updateReq <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (updateAck) begin
                        state     <= ST_IDLE;
                        updateReq <= 1'b0;
                    end else if (frame_step) begin
                        state     <= ST_IDLE;
                        updateReq <= 1'b0;
                        overrun   <= 1'b1;
                        if (overrunCount != 8'hFF) begin
                            overrunCount <= overrunCount + 8'd1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    updateReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer on a shrunken 15x11 raster
// so whole frames, overrun saturation and resets fit in a short run.
module tb_vga_frame_sequencer;

    // Small raster: H 8+2+3+2=15 (hsync 10..12), V 6+1+2+2=11 (vsync 7..8)
    localparam int FRAME = 165;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        ack = 1'b0;
    logic [11:0] color = 12'hF0A;
    logic [3:0]  r, g, b;
    logic        hs, vs, vo, fs, req, ov;
    logic [9:0]  px, py;
    logic [7:0]  cnt;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int tot = 0;

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .CW(10)
    ) dut (
        .boardCLK     (clk),
        .reset        (rst),
        .pixEn        (pix_en),
        .colorIn      (color),
        .updateAck    (ack),
        .redVGA       (r),
        .greenVGA     (g),
        .blueVGA      (b),
        .horizontalVGA(hs),
        .verticalVGA  (vs),
        .pixelX       (px),
        .pixelY       (py),
        .videoOn      (vo),
        .frameStart   (fs),
        .updateReq    (req),
        .overrun      (ov),
        .overrunCount (cnt)
    );

    typedef struct {
        int          k;
        logic [11:0] color;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        vo;
        logic        req;
        logic        fs;
        logic        ov;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel tick every 4 clocks; sampled at the negedge right after it.
    task automatic tick(input logic with_ack);
        repeat (3) @(negedge clk);
        pix_en = 1'b1;
        ack = with_ack;
        @(negedge clk);
        pix_en = 1'b0;
        ack = 1'b0;
        pos = (pos + 1) % FRAME;
        tot++;
    endtask

    task automatic advance_to(input int target);
        for (int n = 0; n < FRAME && pos != target; n++) tick(1'b0);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int hl, vl, fsn;
        //          k   color   x   y hs vs rgb      vo rq fs ov
        tbl[0]  = '{0,  12'hF0A, 0,  0, 1, 1, 12'h000, 1, 0, 0, 0};
        tbl[1]  = '{1,  12'hF0A, 1,  0, 1, 1, 12'hF0A, 1, 0, 0, 0};
        tbl[2]  = '{8,  12'hF0A, 8,  0, 1, 1, 12'hF0A, 0, 0, 0, 0};
        tbl[3]  = '{9,  12'hF0A, 9,  0, 1, 1, 12'h000, 0, 0, 0, 0};
        tbl[4]  = '{11, 12'hF0A, 11, 0, 0, 1, 12'h000, 0, 0, 0, 0};
        tbl[5]  = '{13, 12'hF0A, 13, 0, 0, 1, 12'h000, 0, 0, 0, 0};
        tbl[6]  = '{14, 12'hF0A, 14, 0, 1, 1, 12'h000, 0, 0, 0, 0};
        tbl[7]  = '{15, 12'hF0A, 0,  1, 1, 1, 12'h000, 1, 0, 0, 0};
        tbl[8]  = '{16, 12'h123, 1,  1, 1, 1, 12'h123, 1, 0, 0, 0};
        tbl[9]  = '{90, 12'hFFF, 0,  6, 1, 1, 12'h000, 0, 1, 0, 0};
        tbl[10] = '{91, 12'hF0A, 1,  6, 1, 1, 12'h000, 0, 1, 0, 0};
        tbl[11] = '{105, 12'hF0A, 0, 7, 1, 1, 12'h000, 0, 1, 0, 0};
        tbl[12] = '{106, 12'hF0A, 1, 7, 1, 0, 12'h000, 0, 1, 0, 0};
        tbl[13] = '{116, 12'hF0A, 11, 7, 0, 0, 12'h000, 0, 1, 0, 0};
        tbl[14] = '{135, 12'hF0A, 0, 9, 1, 0, 12'h000, 0, 1, 0, 0};
        tbl[15] = '{136, 12'hF0A, 1, 9, 1, 1, 12'h000, 0, 1, 0, 0};
        tbl[16] = '{164, 12'hF0A, 14, 10, 1, 1, 12'h000, 0, 1, 0, 0};
        tbl[17] = '{165, 12'hF0A, 0, 0, 1, 1, 12'h000, 1, 0, 1, 1};
        tbl[18] = '{166, 12'hF0A, 1, 0, 1, 1, 12'hF0A, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: no ack, so the window closes with an overrun
        for (int i = 0; i < 19; i++) begin
            color = tbl[i].color;
            for (int n = 0; n < 200 && tot < tbl[i].k; n++) tick(1'b0);
            chk($sformatf("vec%0d_k%0d", i, tbl[i].k),
                64'({px, py, hs, vs, r, g, b, vo, req, fs, ov}),
                64'({tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].rgb,
                     tbl[i].vo, tbl[i].req, tbl[i].fs, tbl[i].ov}));
            if (tbl[i].k == 165) chk("ovcnt_frame1", 64'(cnt), 64'd1);
        end
        color = 12'hF0A;

        // Frame 2: per-frame sync and frameStart totals
        hl = 0; vl = 0; fsn = 0;
        for (int n = 0; n < FRAME; n++) begin
            tick(1'b0);
            if (!hs) hl++;
            if (!vs) vl++;
            if (fs) fsn++;
        end
        chk("hsync_low_ticks", 64'(hl), 64'd33);
        chk("vsync_low_ticks", 64'(vl), 64'd30);
        chk("framestart_per_frame", 64'(fsn), 64'd1);
        chk("ovcnt_frame2", 64'(cnt), 64'd2);

        // Frame 3: third consecutive overrun
        advance_to(90);
        chk("req_frame3", 64'(req), 64'd1);
        advance_to(0);
        chk("ov_fs_frame3", 64'({ov, fs, req}), 64'({1'b1, 1'b1, 1'b0}));
        chk("ovcnt_frame3", 64'(cnt), 64'd3);

        // Frame 4: ack mid-vblank
        advance_to(90);
        chk("req_rise_vblank", 64'(req), 64'd1);
        advance_to(130);
        chk("req_before_ack", 64'(req), 64'd1);
        pulse_ack();
        chk("req_after_ack", 64'(req), 64'd0);
        advance_to(0);
        chk("acked_frame_end", 64'({fs, ov, cnt}), 64'({1'b1, 1'b0, 8'd3}));

        // Frame 5: ack on the frame step, then a stray ack in IDLE
        advance_to(164);
        chk("req_before_coincide", 64'(req), 64'd1);
        tick(1'b1);
        chk("coincide_ack", 64'({fs, ov, req, cnt}),
            64'({1'b1, 1'b0, 1'b0, 8'd3}));
        pulse_ack();
        chk("stray_ack", 64'({req, ov, cnt}), 64'({1'b0, 1'b0, 8'd3}));
        advance_to(90);
        chk("req_reraised", 64'(req), 64'd1);
        advance_to(0);
        chk("ovcnt_frame6", 64'({ov, cnt}), 64'({1'b1, 8'd4}));

        // Continuous pixEn: drive the overrun counter into saturation
        @(negedge clk);
        pix_en = 1'b1;
        repeat (251 * FRAME) @(negedge clk);
        chk("ovcnt_reach_255", 64'({fs, ov, cnt}), 64'({1'b1, 1'b1, 8'hFF}));
        repeat (FRAME) @(negedge clk);
        chk("ovcnt_saturated", 64'({fs, ov, cnt}), 64'({1'b1, 1'b1, 8'hFF}));
        pix_en = 1'b0;

        // Asynchronous reset at (3,8) with the request outstanding
        advance_to(123);
        chk("req_before_reset",
            64'({px, py, req, vs}), 64'({10'd3, 10'd8, 1'b1, 1'b0}));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_state",
            64'({px, py, hs, vs, r, g, b, req, fs, ov, cnt}),
            64'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 8'd0}));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pos = 0;
        @(negedge clk);
        chk("no_fs_on_release", 64'({px, py, fs}), 64'd0);
        repeat (20) tick(1'b0);
        chk("restart_count",
            64'({px, py, hs, vs, r, g, b, vo}),
            64'({10'd5, 10'd1, 1'b1, 1'b1, 12'hF0A, 1'b1}));

        // pixEn held low: every output stays put
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            chk($sformatf("hold_%0d", n),
                64'({px, py, hs, vs, r, g, b, vo, req, fs, ov, cnt}),
                64'({10'd5, 10'd1, 1'b1, 1'b1, 12'hF0A, 1'b1,
                     1'b0, 1'b0, 1'b0, 8'd0}));
        end

        // First frameStart after reset is one full frame later
        advance_to(0);
        chk("first_fs_after_reset", 64'({px, py, fs, ov, cnt}),
            64'({10'd0, 10'd0, 1'b1, 1'b1, 8'd1}));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
